// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds the symbol boundary in an unaligned 10-bit word
// stream by hunting for control tokens, then decodes data and control symbols.
module tmds_channel_decoder #(
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOCK_RUN       = 16,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  logic       pixel_clk,
  input  logic       areset,
  input  logic [9:0] din,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       aligned,
  output logic [3:0] bit_offset
);

  localparam int CW = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(SEARCH_TIMEOUT - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(LOCK_RUN - 1);
  localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t        r_state;
  logic [9:0]    r_din_d;
  logic [9:0]    r_sym;
  logic [3:0]    r_off;
  logic [CW-1:0] r_idle;
  logic [CW-1:0] r_run;
  logic [CW-1:0] r_loss;
  logic [7:0]    r_data;
  logic [1:0]    r_ctrl;
  logic          r_de;
  logic          r_aligned;

  logic [18:0]   w_cat;
  logic [9:0]    w_win;
  logic          w_tok;
  logic [1:0]    w_tctl;
  logic [7:0]    w_qp;
  logic [7:0]    w_dec;
  logic [3:0]    w_off_inc;

  // Bit 19 of {din, din_d} is never reachable with offsets 0..9.
  assign w_cat     = {din[8:0], r_din_d};
  assign w_off_inc = (r_off == 4'd9) ? 4'd0 : r_off + 4'd1;

  always_comb begin
    w_win = w_cat[9:0];
    for (int unsigned s = 1; s < 10; s++) begin
      if (r_off == 4'(s)) w_win = w_cat[s +: 10];
    end
  end

  always_comb begin
    w_tok  = 1'b1;
    w_tctl = '0;
    case (r_sym)
      10'h354: w_tctl = 2'b00;
      10'h0AB: w_tctl = 2'b01;
      10'h154: w_tctl = 2'b10;
      10'h2AB: w_tctl = 2'b11;
      default: w_tok  = 1'b0;
    endcase
  end

  always_comb begin
    w_qp     = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
    w_dec    = '0;
    w_dec[0] = w_qp[0];
    for (int unsigned i = 1; i < 8; i++) begin
      w_dec[i] = r_sym[8] ? (w_qp[i] ^ w_qp[i-1]) : ~(w_qp[i] ^ w_qp[i-1]);
    end
  end

  // Output gating follows the state being entered on this edge, so the first
  // gated output coincides with aligned rising.
  always_ff @(posedge pixel_clk or posedge areset) begin
    if (areset) begin
      r_state   <= ST_SEARCH;
      r_din_d   <= '0;
      r_sym     <= '0;
      r_off     <= '0;
      r_idle    <= '0;
      r_run     <= '0;
      r_loss    <= '0;
      r_data    <= '0;
      r_ctrl    <= '0;
      r_de      <= 1'b0;
      r_aligned <= 1'b0;
    end else begin
      r_din_d <= din;
      r_sym   <= w_win;
      r_data  <= w_dec;
      r_ctrl  <= '0;
      r_de    <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_tok) begin
            r_state <= ST_VERIFY;
            r_run   <= CW'(1);
            r_idle  <= '0;
          end else if (r_idle == IDLE_LAST) begin
            r_idle <= '0;
            r_run  <= '0;
            r_off  <= w_off_inc;
          end else begin
            r_idle <= r_idle + CW'(1);
          end
        end
        ST_VERIFY: begin
          if (w_tok) begin
            r_run <= r_run + CW'(1);
            if (r_run == RUN_LAST) begin
              r_state   <= ST_LOCKED;
              r_aligned <= 1'b1;
              r_loss    <= '0;
              r_ctrl    <= w_tctl;
            end
          end else begin
            r_state <= ST_SEARCH;
            r_idle  <= '0;
            r_run   <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_tok) begin
            r_loss <= '0;
            r_ctrl <= w_tctl;
          end else if (r_loss == LOSS_LAST) begin
            r_state   <= ST_SEARCH;
            r_aligned <= 1'b0;
            r_loss    <= '0;
            r_idle    <= '0;
            r_run     <= '0;
            r_off     <= w_off_inc;
          end else begin
            r_loss <= r_loss + CW'(1);
            r_de   <= 1'b1;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  assign data_out   = r_data;
  assign ctrl_out   = r_ctrl;
  assign de_out     = r_de;
  assign aligned    = r_aligned;
  assign bit_offset = r_off;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: directed streams checked every cycle against a
// behavioural model, plus hand-computed expectations at key cycles.
module tb_tmds_channel_decoder;

  localparam int SEARCH_TO = 32;
  localparam int LOCK_RUN  = 4;
  localparam int LOSS_TO   = 64;
  localparam int M_SEARCH  = 0;
  localparam int M_VERIFY  = 1;
  localparam int M_LOCKED  = 2;
  localparam logic [9:0] TOKS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic       pixel_clk;
  logic       areset;
  logic [9:0] din;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       aligned;
  logic [3:0] bit_offset;

  int n_cmp = 0;
  int n_bad = 0;
  int din_tag;
  int disp = 0;

  // model state
  int         m_st, m_idle, m_run, m_loss, m_off;
  logic [9:0] m_prev, m_sym;
  int         m_prev_tag, m_sym_tag;
  logic       e_aligned, e_de;
  logic [1:0] e_ctrl;
  logic [7:0] e_data;
  int         e_tag;

  tmds_channel_decoder #(
    .SEARCH_TIMEOUT(SEARCH_TO),
    .LOCK_RUN      (LOCK_RUN),
    .LOSS_TIMEOUT  (LOSS_TO)
  ) dut (
    .pixel_clk (pixel_clk),
    .areset    (areset),
    .din       (din),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .de_out    (de_out),
    .aligned   (aligned),
    .bit_offset(bit_offset)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int tok_of(input logic [9:0] s);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (s == TOKS[i]) r = i;
    return r;
  endfunction

  // Undo the conditional inversion, then each bit is the XOR (q8=1) or XNOR
  // (q8=0) of neighbouring bits.
  function automatic logic [7:0] dec(input logic [9:0] q);
    logic [7:0] p;
    p = q[9] ? ~q[7:0] : q[7:0];
    return p ^ (p << 1) ^ (q[8] ? 8'h00 : 8'hFE);
  endfunction

  task automatic tmds_encode(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm    = '0;
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disp = qm[8] ? disp + n1q - n0q : disp + n0q - n1q;
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp = disp + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp = disp - (qm[8] ? 0 : 2) + n1q - n0q;
    end
  endtask

  task automatic model_reset();
    m_st = M_SEARCH; m_idle = 0; m_run = 0; m_loss = 0; m_off = 0;
    m_prev = '0; m_sym = '0; m_prev_tag = -1; m_sym_tag = -1;
    e_aligned = 1'b0; e_de = 1'b0; e_ctrl = '0; e_data = '0; e_tag = -1;
  endtask

  task automatic model_step();
    int tok;
    bit moved;
    logic [19:0] cat;
    tok    = tok_of(m_sym);
    moved  = 1'b0;
    e_data = dec(m_sym);
    e_tag  = m_sym_tag;
    if (m_st == M_SEARCH) begin
      if (tok >= 0) begin m_st = M_VERIFY; m_run = 1; end
      else begin
        m_idle = m_idle + 1;
        if (m_idle == SEARCH_TO) moved = 1'b1;
      end
    end else if (m_st == M_VERIFY) begin
      if (tok >= 0) begin
        m_run = m_run + 1;
        if (m_run == LOCK_RUN) m_st = M_LOCKED;
      end else begin
        m_st = M_SEARCH; m_idle = 0;
      end
    end else begin
      if (tok >= 0) m_loss = 0;
      else begin
        m_loss = m_loss + 1;
        if (m_loss == LOSS_TO) begin m_st = M_SEARCH; m_loss = 0; moved = 1'b1; end
      end
    end
    e_aligned = (m_st == M_LOCKED);
    e_de      = e_aligned && (tok < 0);
    e_ctrl    = (e_aligned && tok >= 0) ? 2'(tok) : 2'b00;
    cat       = {din, m_prev} >> m_off;
    m_sym     = cat[9:0];
    m_sym_tag = (m_off == 0) ? m_prev_tag : -1;
    m_prev     = din;
    m_prev_tag = din_tag;
    if (moved) begin m_off = (m_off + 1) % 10; m_idle = 0; m_run = 0; end
  endtask

  always @(posedge pixel_clk or posedge areset) begin
    if (areset) model_reset();
    else        model_step();
  end

  always @(negedge pixel_clk) begin
    if (!areset) begin
      check("aligned",    32'(aligned),    32'(e_aligned));
      check("bit_offset", 32'(bit_offset), 32'(m_off));
      check("de_out",     32'(de_out),     32'(e_de));
      check("ctrl_out",   32'(ctrl_out),   32'(e_ctrl));
      if (e_de || !e_aligned) check("data_out", 32'(data_out), 32'(e_data));
      if (e_de && e_tag >= 0) check("roundtrip", 32'(data_out), 32'(e_tag));
    end
  end

  task automatic drive(input logic [9:0] w, input int tag);
    @(negedge pixel_clk);
    din     = w;
    din_tag = tag;
  endtask

  task automatic reset_dut(input logic [9:0] w);
    @(negedge pixel_clk);
    areset  = 1'b1;
    din     = w;
    din_tag = -1;
    repeat (2) @(negedge pixel_clk);
    areset = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_data"},   32'(data_out),   32'h0);
    check({nm, "_ctrl"},   32'(ctrl_out),   32'h0);
    check({nm, "_de"},     32'(de_out),     32'h0);
    check({nm, "_aligned"},32'(aligned),    32'h0);
    check({nm, "_offset"}, 32'(bit_offset), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] tok, sh, enc;
    areset  = 1'b1;
    din     = '0;
    din_tag = -1;
    repeat (3) @(negedge pixel_clk);
    check_zero("reset");
    areset = 1'b0;

    // aligned lock at offset 0: (8 x 0x354, 0x100) repeated
    for (int i = 0; i < 27; i++) begin
      drive((i % 9 == 8) ? 10'h100 : 10'h354, -1);
      if (i == 5) check("lock_early", 32'(aligned), 32'h0);
      if (i == 6) begin
        check("lock_time", 32'(aligned),  32'h1);
        check("lock_de",   32'(de_out),   32'h0);
        check("lock_ctrl", 32'(ctrl_out), 32'h0);
      end
      if (i == 11) begin
        check("d100_de",   32'(de_out),   32'h1);
        check("d100_data", 32'(data_out), 32'h00);
      end
    end
    drive(10'h2FF, -1);
    repeat (3) drive(10'h354, -1);
    check("d2ff_de",   32'(de_out),   32'h1);
    check("d2ff_data", 32'(data_out), 32'hFE);

    // asynchronous reset while locked
    @(negedge pixel_clk);
    #2 areset = 1'b1;
    #1 check_zero("midreset");
    tok = 10'h2AB;
    sh  = {tok[6:0], tok[9:7]};
    din = sh;
    repeat (2) @(negedge pixel_clk);
    areset = 1'b0;
    check("rel_offset",  32'(bit_offset), 32'h0);
    check("rel_aligned", 32'(aligned),    32'h0);

    // bit-slip search: 0x2AB stream shifted by 3 bits
    for (int i = 0; i < 150; i++) begin
      drive(sh, -1);
      if (i == 30)  check("slip_off0", 32'(bit_offset), 32'h0);
      if (i == 31)  check("slip_off1", 32'(bit_offset), 32'h1);
      if (i == 62)  check("slip_off1b", 32'(bit_offset), 32'h1);
      if (i == 63)  check("slip_off2", 32'(bit_offset), 32'h2);
      if (i == 95)  check("slip_off3", 32'(bit_offset), 32'h3);
      if (i == 99)  check("slip_early", 32'(aligned), 32'h0);
      if (i == 100) begin
        check("slip_lock", 32'(aligned),  32'h1);
        check("slip_ctrl", 32'(ctrl_out), 32'h3);
      end
      if (i == 140) check("slip_hold", 32'(bit_offset), 32'h3);
    end

    // loss of lock after 64 consecutive data symbols
    reset_dut(10'h000);
    for (int i = 0; i < 80; i++) begin
      drive((i < 6) ? 10'h354 : 10'h100, -1);
      if (i == 71) begin
        check("loss_pre_aligned", 32'(aligned),    32'h1);
        check("loss_pre_de",      32'(de_out),     32'h1);
        check("loss_pre_off",     32'(bit_offset), 32'h0);
      end
      if (i == 72) begin
        check("loss_aligned", 32'(aligned),    32'h0);
        check("loss_de",      32'(de_out),     32'h0);
        check("loss_off",     32'(bit_offset), 32'h1);
      end
    end

    // VERIFY broken by one data word
    reset_dut(10'h000);
    for (int i = 0; i < 12; i++) begin
      drive((i == 3) ? 10'h100 : 10'h0AB, -1);
      if (i == 8)  check("brk_off", 32'(bit_offset), 32'h0);
      if (i == 9)  check("brk_early", 32'(aligned), 32'h0);
      if (i == 10) begin
        check("brk_lock", 32'(aligned),  32'h1);
        check("brk_ctrl", 32'(ctrl_out), 32'h1);
      end
    end

    // all 256 bytes through the reference encoder, tokens interleaved
    for (int b = 0; b < 256; b++) begin
      if (b % 16 == 0) drive(10'h154, -1);
      tmds_encode(8'(b), enc);
      drive(enc, b);
    end
    repeat (4) drive(10'h154, -1);
    check("sweep_aligned", 32'(aligned),  32'h1);
    check("sweep_ctrl",    32'(ctrl_out), 32'h2);

    repeat (2) @(negedge pixel_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
